// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and defaults for the instruction/data memory port arbiter.
//   arb_state_e  : sequencer state (IDLE, DATA, FETCH)
//   DEF_AW/DEF_DW: default address / data widths
//   DEF_TIMEOUT  : default cycle limit waiting for mem_ack
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  localparam int DEF_AW      = 32;
  localparam int DEF_DW      = 32;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } arb_state_e;

endpackage

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
// One-entry instruction buffer: tag, data and valid bit, with a hit compare
// against the current fetch address.
//   clk, rst     : clock, synchronous active-high reset
//   lookup_addr  : address compared against the stored tag
//   hit          : buffer holds lookup_addr
//   buf_data     : buffered instruction word (0 after reset)
//   fill_en      : load fill_tag/fill_data and mark valid
//   inv_en       : store seen at inv_addr; drop the entry if it matches
// ---------------------------------------------------------------------------
module fetch_buffer #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] lookup_addr,
  output logic          hit,
  output logic [DW-1:0] buf_data,
  input  logic          fill_en,
  input  logic [AW-1:0] fill_tag,
  input  logic [DW-1:0] fill_data,
  input  logic          inv_en,
  input  logic [AW-1:0] inv_addr
);

  logic          buf_valid;
  logic [AW-1:0] buf_tag;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (fill_en) begin
      buf_valid <= 1'b1;
      buf_tag   <= fill_tag;
      buf_data  <= fill_data;
    end else if (inv_en && (inv_addr == buf_tag)) begin
      // A store over the buffered instruction makes the copy stale.
      buf_valid <= 1'b0;
    end
  end

  assign hit = buf_valid && (buf_tag == lookup_addr);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between instruction fetch and data access.
// Each pipeline step needs its instruction in the fetch buffer and, if
// requested, its load/store done; data goes first, then any fetch miss.
// The pipeline is stalled until both are satisfied.
//   clk, rst                 : clock, synchronous active-high reset
//   if_addr / if_inst        : fetch address in, buffered instruction out
//   dm_addr/read/write/wdata : data request for this step
//   dm_rdata                 : last load result (holds until next load ack)
//   stall                    : pipeline must hold this cycle
//   mem_req/we/addr/wdata    : memory request (registered off state)
//   mem_rdata, mem_ack       : memory response
//   err                      : sticky watchdog timeout flag
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_inst,
  input  logic [AW-1:0] dm_addr,
  input  logic          dm_read,
  input  logic          dm_write,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          err
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  arb_state_e    state, state_nxt;
  logic          hit;
  logic          dm_need;
  logic          d_done;
  logic [WDW-1:0] wd_cnt;
  logic          timeout;
  logic          take_data;
  logic          take_fetch;
  logic          data_ack;
  logic          fetch_ack;

  // Latched request for the access in flight.
  logic [AW-1:0] lat_addr;
  logic          lat_we;
  logic [DW-1:0] lat_wdata;

  fetch_buffer #(.AW(AW), .DW(DW)) u_fetch_buffer (
    .clk         (clk),
    .rst         (rst),
    .lookup_addr (if_addr),
    .hit         (hit),
    .buf_data    (if_inst),
    .fill_en     (fetch_ack),
    .fill_tag    (lat_addr),
    .fill_data   (mem_rdata),
    .inv_en      (data_ack && lat_we),
    .inv_addr    (lat_addr)
  );

  assign dm_need   = dm_read | dm_write;
  assign stall     = !(hit && (!dm_need || d_done));
  assign data_ack  = (state == DATA)  && mem_ack;
  assign fetch_ack = (state == FETCH) && mem_ack;
  // An ack on the last allowed cycle still completes the access.
  assign timeout   = (state != IDLE) && !mem_ack && (wd_cnt == WDW'(TIMEOUT));

  assign mem_req   = (state != IDLE);
  assign mem_we    = (state == DATA) && lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt  = state;
    take_data  = 1'b0;
    take_fetch = 1'b0;
    case (state)
      IDLE: begin
        if (dm_need && !d_done) begin
          state_nxt = DATA;
          take_data = 1'b1;
        end else if (!hit) begin
          state_nxt  = FETCH;
          take_fetch = 1'b1;
        end
      end
      DATA, FETCH: begin
        if (mem_ack || timeout) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Request latch: store wins when read and write are both asserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
    end else if (take_data) begin
      lat_addr  <= dm_addr;
      lat_we    <= dm_write;
      lat_wdata <= dm_wdata;
    end else if (take_fetch) begin
      lat_addr  <= if_addr;
      lat_we    <= 1'b0;
    end
  end

  // d_done: this step's data access has finished. A step advancing on the
  // same edge as an ack must start the next step with d_done clear.
  always_ff @(posedge clk) begin
    if (rst)           d_done <= 1'b0;
    else if (!stall)   d_done <= 1'b0;
    else if (data_ack) d_done <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                      dm_rdata <= '0;
    else if (data_ack && !lat_we) dm_rdata <= mem_rdata;
  end

  // Watchdog: counts waiting cycles; on expiry the access is dropped and
  // the IDLE decision re-issues it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else begin
      if (state == IDLE || mem_ack || timeout) wd_cnt <= '0;
      else                                     wd_cnt <= wd_cnt + 1'b1;
      if (timeout) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Table-driven step vectors, a watchdog sequence, and randomized steps
// checked against a step-level model of buffer, memory and access order.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int TIMEOUT    = 255;
  localparam int STEP_LIMIT = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_inst;
  logic [AW-1:0] dm_addr;
  logic          dm_read;
  logic          dm_write;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;
  logic          err;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .if_addr   (if_addr),
    .if_inst   (if_inst),
    .dm_addr   (dm_addr),
    .dm_read   (dm_read),
    .dm_write  (dm_write),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- memory environment ----------------
  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  logic [DW-1:0] env_mem   [logic [AW-1:0]];
  logic [DW-1:0] model_mem [logic [AW-1:0]];
  acc_t          acc_q[$];
  acc_t          exp_q[$];
  int            mem_mode;   // 0: ack at once, 1: random latency + stray acks, 2: never ack

  function automatic logic [DW-1:0] seed_word(input logic [AW-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [DW-1:0] env_read(input logic [AW-1:0] a);
    return env_mem.exists(a) ? env_mem[a] : seed_word(a);
  endfunction

  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    return model_mem.exists(a) ? model_mem[a] : seed_word(a);
  endfunction

  initial begin
    int lat_left;
    acc_t rec;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    lat_left  = -1;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst !== 1'b0) begin
        lat_left = -1;
      end else if (mem_req) begin
        if (mem_mode != 2) begin
          if (lat_left < 0) lat_left = (mem_mode == 1) ? int'($urandom_range(0, 3)) : 0;
          if (lat_left == 0) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_we ? DW'($urandom) : env_read(mem_addr);
            rec.we    = mem_we;
            rec.addr  = mem_addr;
            rec.wdata = mem_we ? mem_wdata : '0;
            acc_q.push_back(rec);
            if (mem_we) env_mem[mem_addr] = mem_wdata;
            lat_left  = -1;
          end else begin
            lat_left--;
          end
        end
      end else begin
        lat_left = -1;
        if (mem_mode == 1 && $urandom_range(0, 3) == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = DW'($urandom);
        end
      end
    end
  end

  // ---------------- step helpers ----------------
  task automatic apply_reset();
    rst      = 1'b1;
    if_addr  = '0;
    dm_addr  = '0;
    dm_read  = 1'b0;
    dm_write = 1'b0;
    dm_wdata = '0;
    @(posedge clk);
    @(negedge clk);
    check("rst_mem_req",  mem_req,  0);
    check("rst_stall",    stall,    1);
    check("rst_err",      err,      0);
    check("rst_if_inst",  if_inst,  0);
    check("rst_dm_rdata", dm_rdata, 0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Present one step's inputs and wait for stall to drop; returns the
  // number of stalled cycles. Ends sampled at a negedge.
  task automatic do_step(input logic [AW-1:0] ia, input logic rd, input logic wr,
                         input logic [AW-1:0] da, input logic [DW-1:0] wd,
                         output int stall_cyc);
    if_addr  = ia;
    dm_read  = rd;
    dm_write = wr;
    dm_addr  = da;
    dm_wdata = wd;
    acc_q.delete();
    stall_cyc = 0;
    @(negedge clk);
    while (stall && stall_cyc < STEP_LIMIT) begin
      stall_cyc++;
      @(negedge clk);
    end
    if (stall) check("step_bound_expired", 1, 0);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_accesses(input string tag);
    check({tag, "_nacc"}, acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      check({tag, "_we"},   acc_q[i].we,   exp_q[i].we);
      check({tag, "_addr"}, acc_q[i].addr, exp_q[i].addr);
      if (exp_q[i].we) check({tag, "_wdata"}, acc_q[i].wdata, exp_q[i].wdata);
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [AW-1:0] ia;
    logic          rd;
    logic          wr;
    logic [AW-1:0] da;
    logic [DW-1:0] wd;
    int            exp_stall;
    logic [DW-1:0] exp_inst;
    logic [DW-1:0] exp_rdata;
    int            exp_nacc;
    logic          exp_we;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_wdata;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int sc;
    int n;
    logic          mb_valid;
    logic [AW-1:0] mb_tag;
    logic [DW-1:0] mb_data;
    logic [DW-1:0] m_rdata;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] wd;
    logic          rd, wr;
    acc_t          e;

    // ifaddr   rd wr  daddr   wdata   stall inst          rdata         nacc we addr    wdata
    vecs[0] = '{32'h0, 0, 0, 32'h0,   32'h0,    2, 32'h2002000A, 32'h0,        1, 0, 32'h0,   32'h0};
    vecs[1] = '{32'h0, 0, 0, 32'h0,   32'h0,    0, 32'h2002000A, 32'h0,        0, 0, 32'h0,   32'h0};
    vecs[2] = '{32'h4, 0, 0, 32'h0,   32'h0,    2, 32'h00400093, 32'h0,        1, 0, 32'h4,   32'h0};
    vecs[3] = '{32'h4, 1, 0, 32'h100, 32'h0,    2, 32'h00400093, 32'hDEADBEEF, 1, 0, 32'h100, 32'h0};
    vecs[4] = '{32'h8, 0, 1, 32'h200, 32'h55,   4, 32'h11111111, 32'hDEADBEEF, 2, 1, 32'h200, 32'h55};
    vecs[5] = '{32'hC, 0, 0, 32'h0,   32'h0,    2, 32'h22222222, 32'hDEADBEEF, 1, 0, 32'hC,   32'h0};
    vecs[6] = '{32'hC, 0, 1, 32'hC,   32'h1234, 4, 32'h00001234, 32'hDEADBEEF, 2, 1, 32'hC,   32'h1234};
    vecs[7] = '{32'hC, 1, 1, 32'h300, 32'h7,    2, 32'h00001234, 32'hDEADBEEF, 1, 1, 32'h300, 32'h7};
    vecs[8] = '{32'hC, 1, 0, 32'h300, 32'h0,    2, 32'h00001234, 32'h7,        1, 0, 32'h300, 32'h0};

    env_mem[32'h0]   = 32'h2002000A;
    env_mem[32'h4]   = 32'h00400093;
    env_mem[32'h8]   = 32'h11111111;
    env_mem[32'hC]   = 32'h22222222;
    env_mem[32'h100] = 32'hDEADBEEF;
    mem_mode = 0;

    apply_reset();
    for (int i = 0; i < 9; i++) begin
      do_step(vecs[i].ia, vecs[i].rd, vecs[i].wr, vecs[i].da, vecs[i].wd, sc);
      check($sformatf("vec%0d_stall_cycles", i), sc, vecs[i].exp_stall);
      check($sformatf("vec%0d_if_inst", i), if_inst, vecs[i].exp_inst);
      check($sformatf("vec%0d_dm_rdata", i), dm_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_nacc", i), acc_q.size(), vecs[i].exp_nacc);
      if (vecs[i].exp_nacc > 0 && acc_q.size() > 0) begin
        check($sformatf("vec%0d_first_we", i),   acc_q[0].we,   vecs[i].exp_we);
        check($sformatf("vec%0d_first_addr", i), acc_q[0].addr, vecs[i].exp_addr);
        if (vecs[i].exp_we)
          check($sformatf("vec%0d_first_wdata", i), acc_q[0].wdata, vecs[i].exp_wdata);
      end
      if (vecs[i].exp_nacc == 2 && acc_q.size() == 2) begin
        check($sformatf("vec%0d_second_is_fetch", i), acc_q[1].we, 0);
        check($sformatf("vec%0d_second_addr", i), acc_q[1].addr, vecs[i].ia);
      end
      advance();
    end

    // ---------------- watchdog: memory never acks ----------------
    mem_mode = 2;
    apply_reset();
    if_addr  = 32'h0;
    dm_addr  = 32'h40;
    dm_read  = 1'b1;
    dm_write = 1'b0;
    n = 0;
    for (int c = 0; c < 4 * TIMEOUT && err !== 1'b1; c++) begin
      @(negedge clk);
      if (err !== 1'b1 && mem_req) begin
        n++;
        if (n == 1) begin
          check("wd_first_we",   mem_we,   0);
          check("wd_first_addr", mem_addr, 32'h40);
        end
      end
    end
    check("wd_err_set",        err,     1);
    check("wd_req_cycles",     n,       TIMEOUT + 1);
    check("wd_abandon_req",    mem_req, 0);
    check("wd_stall_held",     stall,   1);
    @(negedge clk);
    check("wd_reissue_req",    mem_req, 1);
    check("wd_reissue_addr",   mem_addr, 32'h40);
    check("wd_reissue_we",     mem_we,  0);
    check("wd_err_sticky",     err,     1);
    check("wd_stall_still",    stall,   1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("wd_rst_err",        err,     0);
    check("wd_rst_req",        mem_req, 0);
    #1 rst = 1'b0;

    // ---------------- randomized steps vs. model ----------------
    mem_mode = 1;
    env_mem.delete();
    model_mem.delete();
    apply_reset();
    mb_valid = 1'b0;
    mb_tag   = '0;
    mb_data  = '0;
    m_rdata  = '0;
    for (int s = 0; s < 60; s++) begin
      int op;
      ia = AW'($urandom_range(0, 15)) << 2;
      op = $urandom_range(0, 3);
      rd = (op == 1) || (op == 3);
      wr = (op >= 2);
      da = ($urandom_range(0, 1) == 0) ? (AW'($urandom_range(0, 15)) << 2)
                                       : (32'h100 + (AW'($urandom_range(0, 7)) << 2));
      wd = DW'($urandom);

      exp_q.delete();
      if (rd || wr) begin
        if (wr) begin
          e = '{we: 1'b1, addr: da, wdata: wd};
          exp_q.push_back(e);
          model_mem[da] = wd;
          if (mb_valid && mb_tag == da) mb_valid = 1'b0;
        end else begin
          e = '{we: 1'b0, addr: da, wdata: '0};
          exp_q.push_back(e);
          m_rdata = model_read(da);
        end
      end
      if (!(mb_valid && mb_tag == ia)) begin
        e = '{we: 1'b0, addr: ia, wdata: '0};
        exp_q.push_back(e);
        mb_valid = 1'b1;
        mb_tag   = ia;
        mb_data  = model_read(ia);
      end

      do_step(ia, rd, wr, da, wd, sc);
      check($sformatf("rnd%0d_if_inst", s),  if_inst,  mb_data);
      check($sformatf("rnd%0d_dm_rdata", s), dm_rdata, m_rdata);
      compare_accesses($sformatf("rnd%0d", s));
      if (exp_q.size() == 0) check($sformatf("rnd%0d_no_stall", s), sc, 0);
      else check($sformatf("rnd%0d_min_cost", s), (sc >= 2 * exp_q.size()), 1);
      check($sformatf("rnd%0d_err", s), err, 0);
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation did not complete, checks=%0d", checks);
    $fatal(1, "time limit");
  end

endmodule
